// File: rtl/ins_cache_sa.sv
// ins_cache_sa -- parametrised set-associative instruction cache.
//
// Accepts trace commands (n, add_in) over a valid/ready handshake:
//   n = 2  instruction fetch, n = 8  clear cache, anything else  no-op.
// A fetch looks the line up in one cycle (true-LRU across WAYS ways) and on a
// miss requests the line from the next level, holding mem_req/add_out until
// mem_valid. The addressed 32-bit word is returned on data_out/data_valid and
// each fetch pulses either hit or miss.
//
// Optional feature (macro INS_CACHE_STATS_EN): adds saturating 32-bit
// hit_count / miss_count outputs, cleared by rst and by an accepted clear.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   n, add_in, req_valid   command in;  req_ready  command accepted when high
//   d_in, mem_valid        line fill from next level (byte 0 in bits [7:0])
//   mem_req, add_out       line fetch request, line-aligned address
//   data_out, data_valid   instruction word and its one-cycle valid
//   hit, miss              one-cycle statistics pulses
module ins_cache_sa #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int SETS       = 16384,
    parameter int WAYS       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              n,
    input  logic [ADDR_W-1:0]       add_in,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [8*LINE_BYTES-1:0] d_in,
    input  logic                    mem_valid,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       add_out,
    output logic [31:0]             data_out,
    output logic                    data_valid,
    output logic                    hit,
    output logic                    miss
`ifdef INS_CACHE_STATS_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
`endif
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WAY_W  = AGE_W;
    localparam int LINE_W = 8 * LINE_BYTES;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_LOOKUP = 3'd2,
        S_FILL   = 3'd3,
        S_CLEAR  = 3'd4
    } state_t;

    typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;

    // Per-set storage. Valid bits and ages are re-initialised by the
    // INIT/CLEAR walk, so none of the arrays need a reset.
    logic [WAYS-1:0]             valid_mem [SETS];
    logic [WAYS-1:0][TAG_W-1:0]  tag_mem   [SETS];
    ages_t                       age_mem   [SETS];
    logic [LINE_W-1:0]           line_mem  [SETS][WAYS];

    state_t              state;
    logic [IDX_W-1:0]    clr_idx;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [WAY_W-1:0]    victim_r;

    logic [IDX_W-1:0]    idx_s;
    logic [TAG_W-1:0]    tag_s;
    logic [OFF_W-1:0]    off_s;
    logic [WAYS-1:0]     set_valid_s;
    ages_t               set_age_s;
    logic [WAYS-1:0]     match_s;
    logic                hit_s;
    logic [WAY_W-1:0]    hit_way_s;
    logic [WAY_W-1:0]    inv_way_s;
    logic [WAY_W-1:0]    old_way_s;
    logic [WAY_W-1:0]    victim_s;
    logic                clr_we_s;

    // Touch way w: younger ways age by one, w becomes MRU. Keeps the ages a
    // permutation of 0..WAYS-1.
    function automatic ages_t lru_touch(input ages_t ages, input logic [WAY_W-1:0] way);
        ages_t res;
        res = ages;
        for (int i = 0; i < WAYS; i++) begin
            res[i] = (ages[i] < ages[way]) ? ages[i] + AGE_W'(1) : ages[i];
        end
        res[way] = '0;
        return res;
    endfunction

    // Initial ages equal the way number.
    function automatic ages_t init_ages();
        ages_t res;
        for (int i = 0; i < WAYS; i++) begin
            res[i] = AGE_W'(i);
        end
        return res;
    endfunction

    // Select the 32-bit word addressed by the line offset; bits [1:0] drop out.
    function automatic logic [31:0] pick_word(input logic [LINE_W-1:0] line,
                                              input logic [OFF_W-1:0] off);
        int wi;
        wi = int'(off) >> 2;
        return line[wi*32 +: 32];
    endfunction

`ifdef INS_CACHE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
`endif

    assign idx_s       = cmd_addr[OFF_W +: IDX_W];
    assign tag_s       = cmd_addr[ADDR_W-1 -: TAG_W];
    assign off_s       = cmd_addr[OFF_W-1:0];
    assign set_valid_s = valid_mem[idx_s];
    assign set_age_s   = age_mem[idx_s];
    assign clr_we_s    = (state == S_INIT) || (state == S_CLEAR);

    // Tag compare and victim choice for the registered command address.
    always_comb begin
        match_s   = '0;
        hit_way_s = '0;
        inv_way_s = '0;
        old_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            match_s[w] = set_valid_s[w] && (tag_mem[idx_s][w] == tag_s);
        end
        // Descending scans so the lowest-numbered candidate wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way_s = match_s[w] ? WAY_W'(w) : hit_way_s;
            inv_way_s = !set_valid_s[w] ? WAY_W'(w) : inv_way_s;
            old_way_s = (set_age_s[w] == AGE_W'(WAYS - 1)) ? WAY_W'(w) : old_way_s;
        end
        hit_s    = |match_s;
        victim_s = (&set_valid_s) ? old_way_s : inv_way_s;
    end

    // Storage writes: clear walk, LRU touch on hit, line install on fill.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we_s) begin
                valid_mem[clr_idx] <= '0;
                age_mem[clr_idx]   <= init_ages();
            end else if ((state == S_LOOKUP) && hit_s) begin
                age_mem[idx_s] <= lru_touch(set_age_s, hit_way_s);
            end else if ((state == S_FILL) && mem_valid) begin
                valid_mem[idx_s][victim_r] <= 1'b1;
                tag_mem[idx_s][victim_r]   <= tag_s;
                line_mem[idx_s][victim_r]  <= d_in;
                age_mem[idx_s]             <= lru_touch(set_age_s, victim_r);
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_INIT;
            clr_idx    <= '0;
            cmd_addr   <= '0;
            victim_r   <= '0;
            req_ready  <= 1'b0;
            mem_req    <= 1'b0;
            add_out    <= '0;
            data_out   <= 32'd0;
            data_valid <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
`ifdef INS_CACHE_STATS_EN
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
`endif
        end else begin
            hit        <= 1'b0;
            miss       <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                S_INIT, S_CLEAR: begin
                    if (clr_idx == IDX_W'(SETS - 1)) begin
                        clr_idx   <= '0;
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + IDX_W'(1);
                    end
                end
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        cmd_addr <= add_in;
                        if (n == 4'd2) begin
                            state     <= S_LOOKUP;
                            req_ready <= 1'b0;
                        end else if (n == 4'd8) begin
                            state     <= S_CLEAR;
                            req_ready <= 1'b0;
                            clr_idx   <= '0;
`ifdef INS_CACHE_STATS_EN
                            hit_count  <= 32'd0;
                            miss_count <= 32'd0;
`endif
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_LOOKUP: begin
                    if (hit_s) begin
                        hit        <= 1'b1;
                        data_valid <= 1'b1;
                        data_out   <= pick_word(line_mem[idx_s][hit_way_s], off_s);
                        state      <= S_IDLE;
                        req_ready  <= 1'b1;
`ifdef INS_CACHE_STATS_EN
                        hit_count  <= sat_inc(hit_count);
`endif
                    end else begin
                        miss     <= 1'b1;
                        victim_r <= victim_s;
                        mem_req  <= 1'b1;
                        add_out  <= {cmd_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        state    <= S_FILL;
`ifdef INS_CACHE_STATS_EN
                        miss_count <= sat_inc(miss_count);
`endif
                    end
                end
                S_FILL: begin
                    if (mem_valid) begin
                        mem_req    <= 1'b0;
                        data_valid <= 1'b1;
                        data_out   <= pick_word(d_in, off_s);
                        state      <= S_IDLE;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_INIT;
                    clr_idx   <= '0;
                    req_ready <= 1'b0;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ins_cache_sa.sv
// Self-checking bench for ins_cache_sa (SETS=4, WAYS=2, LINE_BYTES=64).
// Stimulus pushes expected responses into a scoreboard queue; a monitor pops
// and compares whenever the cache pulses hit/miss/data_valid. The reference
// model keeps, per set, a list of resident line addresses ordered MRU first.
module tb_ins_cache_sa;

    localparam int ADDR_W = 32;
    localparam int LB     = 64;
    localparam int SETS   = 4;
    localparam int WAYS   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        n = 4'd0;
    logic [ADDR_W-1:0] add_in = '0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [8*LB-1:0]   d_in = '0;
    logic              mem_valid;
    logic              mem_req;
    logic [ADDR_W-1:0] add_out;
    logic [31:0]       data_out;
    logic              data_valid;
    logic              hit;
    logic              miss;
`ifdef INS_CACHE_STATS_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    logic stub_valid  = 1'b0;
    logic stray_valid = 1'b0;
    logic stub_hold   = 1'b0;
    assign mem_valid = stub_valid | stray_valid;

    ins_cache_sa #(.ADDR_W(ADDR_W), .LINE_BYTES(LB), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst), .n(n), .add_in(add_in), .req_valid(req_valid),
        .req_ready(req_ready), .d_in(d_in), .mem_valid(mem_valid), .mem_req(mem_req),
        .add_out(add_out), .data_out(data_out), .data_valid(data_valid),
        .hit(hit), .miss(miss)
`ifdef INS_CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int m_hits = 0;
    int m_misses = 0;

    typedef struct {
        bit          is_hit;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fill_q[$];
    logic [31:0] mdl[SETS][$];
    bit          miss_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
        end
    endtask

    // Line contents served by the next-level stub.
    function automatic logic [31:0] gen_word(input logic [31:0] la, input int k);
        if (la == 32'h0000_1040) return 32'hA000_0000 + 32'(k);
        return la ^ (32'h0101_0101 * 32'(k)) ^ 32'h5A5A_0000;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) mdl[s].delete();
        m_hits = 0;
        m_misses = 0;
    endfunction

    // True LRU: hit moves the line to the front; miss inserts at the front
    // and drops the least recently used line when the set overflows.
    function automatic bit model_access(input logic [31:0] addr);
        logic [31:0] la;
        int s;
        int pos;
        la  = addr & 32'hFFFF_FFC0;
        s   = int'((addr >> 6) & 32'h3);
        pos = -1;
        for (int i = 0; i < mdl[s].size(); i++) begin
            if (mdl[s][i] == la) pos = i;
        end
        if (pos >= 0) begin
            mdl[s].delete(pos);
            mdl[s].push_front(la);
            return 1'b1;
        end
        mdl[s].push_front(la);
        if (mdl[s].size() > WAYS) void'(mdl[s].pop_back());
        return 1'b0;
    endfunction

    // Count rising edges until req_ready is seen high.
    task automatic count_ready(input string name);
        int cnt;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!req_ready && cnt < 64);
        check(name, 32'(cnt), 32'd4);
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [31:0] addr);
        int   budget;
        exp_t e;
        bit   h;
        budget = 0;
        @(negedge clk);
        while (!req_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        if (cmd == 4'd2) begin
            h = model_access(addr);
            e.is_hit = h;
            e.data   = gen_word(addr & 32'hFFFF_FFC0, int'((addr >> 2) & 32'hF));
            exp_q.push_back(e);
            if (h) m_hits++;
            else begin
                m_misses++;
                fill_q.push_back(addr & 32'hFFFF_FFC0);
            end
        end
        n = cmd;
        add_in = addr;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 4'($urandom_range(0, 15));
        if (cmd == 4'd2) begin
            @(posedge clk);
            #1;
            check("lookup_pulse", {31'd0, hit | miss}, 32'd1);
        end else if (cmd == 4'd8) begin
            model_reset();
            count_ready("clear_cycles");
`ifdef INS_CACHE_STATS_EN
            check("clear_hit_count", hit_count, 32'd0);
            check("clear_miss_count", miss_count, 32'd0);
`endif
        end else begin
            check("noop_ready", {31'd0, req_ready}, 32'd1);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare every DUT pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            miss_seen = 1'b0;
        end else begin
            if (hit && miss) check("hit_and_miss", 32'd1, 32'd0);
            if (hit || miss) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, hit, miss}, 32'd0);
                end else begin
                    check("hit_kind", {31'd0, hit}, {31'd0, exp_q[0].is_hit});
                    if (hit) begin
                        check("hit_data_valid", {31'd0, data_valid}, 32'd1);
                        check("hit_data", data_out, exp_q[0].data);
                        void'(exp_q.pop_front());
                    end else begin
                        check("miss_no_data", {31'd0, data_valid}, 32'd0);
                        miss_seen = 1'b1;
                    end
                end
            end else if (data_valid) begin
                if (exp_q.size() == 0 || !miss_seen) begin
                    check("unexpected_data_valid", 32'd1, 32'd0);
                end else begin
                    check("fill_data", data_out, exp_q[0].data);
                    void'(exp_q.pop_front());
                    miss_seen = 1'b0;
                end
            end
        end
    end

    // Next-level stub: answers each fill request after a random delay.
    always begin
        @(negedge clk);
        if (rst) begin
            fill_q.delete();
        end else if (mem_req && !stub_hold) begin
            logic [31:0]   la;
            logic [8*LB-1:0] line_v;
            int            dly;
            if (fill_q.size() == 0) begin
                check("unexpected_mem_req", add_out, 32'd0);
                la = add_out;
            end else begin
                la = fill_q.pop_front();
                check("fill_addr", add_out, la);
            end
            dly = $urandom_range(0, 3);
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                check("mem_req_held", {31'd0, mem_req}, 32'd1);
                check("add_out_held", add_out, la);
            end
            for (int k = 0; k < LB / 4; k++) line_v[k*32 +: 32] = gen_word(la, k);
            d_in = line_v;
            stub_valid = 1'b1;
            @(negedge clk);
            stub_valid = 1'b0;
            d_in = '0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        int          pick;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_flags", {27'd0, req_ready, mem_req, data_valid, hit, miss}, 32'd0);
        check("rst_add_out", add_out, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        rst = 1'b0;
        count_ready("init_cycles");

        // Cold miss then hit on the same line.
        issue(4'd2, 32'h0000_1048);
        issue(4'd2, 32'h0000_104C);
        drain();

        // LRU eviction in set 0.
        issue(4'd2, 32'h0000_0000);
        issue(4'd2, 32'h0000_0100);
        issue(4'd2, 32'h0000_0000);
        issue(4'd2, 32'h0000_0200);
        issue(4'd2, 32'h0000_0004);
        issue(4'd2, 32'h0000_0108);
        drain();

        // Clear, then the same line misses again.
        issue(4'd8, 32'h0000_0000);
        issue(4'd2, 32'h0000_0000);
        drain();

        // Randomised command stream.
        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 99);
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 6)
              | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) a = a | 32'h8000_0000;
            if (r < 82) begin
                issue(4'd2, a);
            end else if (r < 86) begin
                drain();
                issue(4'd8, a);
            end else begin
                pick = $urandom_range(0, 15);
                if (pick == 2 || pick == 8) pick = 9;
                issue(4'(pick), a);
            end
        end
        drain();
`ifdef INS_CACHE_STATS_EN
        check("hit_count", hit_count, 32'(m_hits));
        check("miss_count", miss_count, 32'(m_misses));
`endif

        // Reset in the middle of a fill.
        stub_hold = 1'b1;
        issue(4'd2, 32'h5000_0000);
        check("fill_pending", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mem_req_async_drop", {31'd0, mem_req}, 32'd0);
        check("ready_in_rst", {31'd0, req_ready}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_ready("reinit_cycles");
        stub_hold = 1'b0;
        @(negedge clk);
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        issue(4'd9, 32'h0000_0000);
        issue(4'd3, 32'h0000_1048);
        repeat (3) @(negedge clk);
        issue(4'd2, 32'h5000_0008);
        drain();
`ifdef INS_CACHE_STATS_EN
        check("final_miss_count", miss_count, 32'(m_misses));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
